// File: rtl/rpd_sched_pkg.sv
// Shared types for the window scheduler and its round-robin arbiter.
package rpd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Index width for an n-entry one-hot vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pure combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
    import rpd_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        cand  = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        pick = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/window_scheduler.sv
// Shared free-running tick counter plus round-robin arbitration of timed windows.
module window_scheduler
    import rpd_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CTR_WIDTH = 22,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_ce,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*LEN_WIDTH-1:0] i_len,
    output logic [CTR_WIDTH-1:0]         o_ctr,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic                         o_active,
    output logic [NUM_REQ-1:0]           o_done,
    output logic                         o_aborted
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic [CTR_WIDTH-1:0]   target, target_nxt;
    logic [NUM_REQ-1:0]     grant_nxt, done_nxt;
    logic                   active_nxt, aborted_nxt;

    logic [NUM_REQ-1:0]     arb_pick;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    logic [LEN_WIDTH-1:0]   len_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]   sel_len, eff_len;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_len
        assign len_arr[k] = i_len[k*LEN_WIDTH +: LEN_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .pick  (arb_pick),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Zero-length requests still get a one-tick window.
    assign sel_len = len_arr[arb_idx];
    assign eff_len = (sel_len == '0) ? LEN_WIDTH'(1) : sel_len;

    // Timebase runs regardless of scheduler state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ctr <= '0;
        end else if (i_ce) begin
            o_ctr <= o_ctr + CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            ptr       <= '0;
            target    <= '0;
            o_grant   <= '0;
            o_active  <= 1'b0;
            o_done    <= '0;
            o_aborted <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            ptr       <= ptr_nxt;
            target    <= target_nxt;
            o_grant   <= grant_nxt;
            o_active  <= active_nxt;
            o_done    <= done_nxt;
            o_aborted <= aborted_nxt;
        end
    end

    // Expiry is checked before release so a coincident drop is not an abort.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        ptr_nxt     = ptr;
        target_nxt  = target;
        grant_nxt   = o_grant;
        done_nxt    = '0;
        aborted_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_nxt  = ACTIVE;
                    idx_nxt    = arb_idx;
                    target_nxt = o_ctr + CTR_WIDTH'(eff_len);
                    grant_nxt  = arb_pick;
                end
            end
            ACTIVE: begin
                if (o_ctr == target) begin
                    state_nxt = DONE;
                    grant_nxt = '0;
                    done_nxt  = o_grant;
                end else if (!i_req[idx]) begin
                    state_nxt   = DONE;
                    grant_nxt   = '0;
                    done_nxt    = o_grant;
                    aborted_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ptr_nxt   = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase

        active_nxt = |grant_nxt;
    end

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler with a completed-window scoreboard.
module tb_window_scheduler;

    typedef struct {
        logic [3:0]  done;
        logic        ab;
        int          glen;
        logic        chk;
        logic [21:0] ctr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [3:0]  req;
    logic [63:0] len;
    logic [21:0] ctr;
    logic [3:0]  grant;
    logic        active;
    logic [3:0]  done;
    logic        aborted;

    logic        ce_w;
    logic [3:0]  req_w;
    logic [23:0] len_w;
    logic [7:0]  ctr_w;
    logic [3:0]  grant_w;
    logic        active_w;
    logic [3:0]  done_w;
    logic        aborted_w;

    int   compared   = 0;
    int   mismatched = 0;
    logic toggle_ce  = 1'b0;
    exp_t exp_q[$];

    window_scheduler #(.NUM_REQ(4), .CTR_WIDTH(22), .LEN_WIDTH(16)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_req(req), .i_len(len),
        .o_ctr(ctr), .o_grant(grant), .o_active(active), .o_done(done), .o_aborted(aborted)
    );

    window_scheduler #(.NUM_REQ(4), .CTR_WIDTH(8), .LEN_WIDTH(6)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_ce(ce_w), .i_req(req_w), .i_len(len_w),
        .o_ctr(ctr_w), .o_grant(grant_w), .o_active(active_w), .o_done(done_w), .o_aborted(aborted_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_ce) ce = ~ce;
    endtask

    task automatic push(input logic [3:0] d, input logic ab, input int glen,
                        input logic chk, input logic [21:0] c);
        exp_t e;
        e.done = d; e.ab = ab; e.glen = glen; e.chk = chk; e.ctr = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (done == '0 && i < budget);
        compared++;
        assert (done != '0) else begin
            mismatched++;
            $error("FAIL done_timeout: observed=%0h expected=nonzero after %0d cycles", done, budget);
        end
    endtask

    // Scoreboard: measure each window and compare it when o_done fires.
    int gcnt = 0;
    int gap  = 0;
    bit seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            gcnt = 0;
            gap  = 0;
            seen = 1'b0;
        end else begin
            check("active_or", 32'(active), 32'(|grant));
            if (grant != '0) begin
                if (gcnt == 0 && seen) check("min_gap", 32'(gap >= 2), 32'd1);
                check("grant_onehot", 32'($onehot(grant)), 32'd1);
                gcnt++;
                gap = 0;
            end else begin
                gap++;
            end
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", 32'(done), 32'(e.done));
                    check("aborted", 32'(aborted), 32'(e.ab));
                    check("grant_cycles", 32'(gcnt), 32'(e.glen));
                    if (e.chk) check("ctr_at_done", 32'(ctr), 32'(e.ctr));
                end
                gcnt = 0;
                seen = 1'b1;
            end else begin
                check("aborted_idle", 32'(aborted), 32'd0);
            end
        end
    end

    initial begin
        int          n;
        logic [7:0]  last;
        logic [21:0] c;

        rst = 1'b1; ce = 1'b0; req = '0; len = '0;
        ce_w = 1'b0; req_w = '0; len_w = '0;
        step(); step();
        check("rst_ctr", 32'(ctr), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        rst = 1'b0;
        ce_w = 1'b1;

        // Wrap-around on the 8-bit instance: grant at ctr 250, length 10.
        n = 0;
        while (ctr_w != 8'd250 && n < 300) begin step(); n++; end
        check("t3_reach_250", 32'(ctr_w), 32'd250);
        req_w = 4'b0001;
        len_w[5:0] = 6'd10;
        step();
        check("t3_grant", 32'(grant_w), 32'd1);
        check("t3_target", 32'(u_wrap.target), 32'd4);
        n = 0; last = '0;
        while (grant_w != '0 && n < 20) begin last = ctr_w; n++; step(); end
        check("t3_len", 32'(n), 32'd10);
        check("t3_last_ctr", 32'(last), 32'd4);
        check("t3_done", 32'(done_w), 32'd1);
        check("t3_aborted", 32'(aborted_w), 32'd0);
        check("t3_active", 32'(active_w), 32'd0);
        req_w = '0;
        ce_w = 1'b0;

        // Single window of 5 ticks sampled at ctr 10.
        ce = 1'b1;
        len[15:0] = 16'd5;
        n = 0;
        while (ctr != 22'd10 && n < 50) begin step(); n++; end
        check("t1_reach_10", 32'(ctr), 32'd10);
        req = 4'b0001;
        push(4'b0001, 1'b0, 5, 1'b1, 22'd16);
        step();
        check("t1_grant_latency", 32'(grant), 32'd1);
        wait_done(20);
        req = '0;
        step();
        check("t1_gap1", 32'(grant), 32'd0);
        step();
        check("t1_gap2", 32'(grant), 32'd0);

        // Round-robin from a fresh pointer, all held, length 3.
        rst = 1'b1; step(); step(); rst = 1'b0;
        len = {16'd3, 16'd3, 16'd3, 16'd3};
        push(4'b0001, 1'b0, 3, 1'b0, '0);
        push(4'b0010, 1'b0, 3, 1'b0, '0);
        push(4'b0100, 1'b0, 3, 1'b0, '0);
        push(4'b1000, 1'b0, 3, 1'b0, '0);
        push(4'b0001, 1'b0, 3, 1'b0, '0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(20);
        req = '0;
        step(); step();

        // Tick gating: ce alternates, starting low on the sampling edge.
        len[15:0] = 16'd4;
        toggle_ce = 1'b1;
        step();
        if (ce != 1'b0) step();
        c = ctr;
        req = 4'b0001;
        push(4'b0001, 1'b0, 8, 1'b1, c + 22'd4);
        wait_done(40);
        req = '0;
        toggle_ce = 1'b0;
        ce = 1'b1;
        step(); step();

        // Early release on the second grant cycle.
        len[47:32] = 16'd6;
        req = 4'b0100;
        push(4'b0100, 1'b1, 2, 1'b0, '0);
        step();
        check("t5_grant", 32'(grant), 32'b0100);
        step();
        req = '0;
        wait_done(10);
        step(); step();

        // Release on the cycle where ctr equals target: expiry wins.
        len[47:32] = 16'd3;
        req = 4'b0100;
        push(4'b0100, 1'b0, 3, 1'b0, '0);
        step(); step(); step();
        req = '0;
        wait_done(10);
        step(); step();

        // Reset mid-window, then requester 0 wins first.
        len[31:16] = 16'd10;
        req = 4'b0010;
        step();
        check("t6_grant", 32'(grant), 32'b0010);
        step(); step();
        #2 rst = 1'b1;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_ctr", 32'(ctr), 32'd0);
        check("t6_async_done", 32'(done), 32'd0);
        check("t6_async_active", 32'(active), 32'd0);
        req = 4'b0011;
        len[15:0] = 16'd2;
        step();
        check("t6_hold_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        push(4'b0001, 1'b0, 2, 1'b0, '0);
        wait_done(20);
        req = '0;
        step(); step();

        // Zero length gives a single-cycle window.
        len[63:48] = 16'd0;
        c = ctr;
        req = 4'b1000;
        push(4'b1000, 1'b0, 1, 1'b1, c + 22'd2);
        wait_done(10);
        req = '0;
        step(); step(); step();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
